// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//
// Definitions shared by the RV32M multiply/divide sequencer:
//   - sequencer state encoding
//   - funct3 encodings of the eight M-extension operations
//   - iteration count and counter width
//   - special-case result constants
//   - small decode helpers on funct3
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      F3_MUL    = 3'd0,
      F3_MULH   = 3'd1,
      F3_MULHSU = 3'd2,
      F3_MULHU  = 3'd3,
      F3_DIV    = 3'd4,
      F3_DIVU   = 3'd5,
      F3_REM    = 3'd6,
      F3_REMU   = 3'd7
   } funct3_e;

   // One shift-add or shift-subtract step per operand bit.
   localparam int MULDIV_CYCLES = 32;
   localparam int CNT_W         = $clog2(MULDIV_CYCLES);

   // Quotient of a divide by zero, and the divisor of the signed-overflow case.
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
   // Most negative 32-bit value: dividend of the overflow case and its quotient.
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;

   // funct3[2] separates the divide group from the multiply group.
   function automatic logic is_div_op(input logic [2:0] f);
      return f[2];
   endfunction

   // REM/REMU (funct3[1] set within the divide group) deliver the remainder.
   function automatic logic is_rem_op(input logic [2:0] f);
      return f[2] & f[1];
   endfunction

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
   function automatic logic op_a_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM.
   function automatic logic op_b_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
//
// Conditional two's-complement negation. Used to turn signed operands into
// magnitudes on entry and to restore the sign of the product, quotient or
// remainder on exit.
//
// Ports:
//   neg_i  in  1  negate when set, pass through when clear
//   val_i  in  W  input value
//   res_o  out W  val_i or -val_i
// -----------------------------------------------------------------------------
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Operands
// arrive already forwarded; a shift-add multiplier or a restoring divider runs
// over 32 cycles while stall_req freezes IF/ID/EX, then FIXUP restores signs
// and selects the result word, and DONE pulses done for one cycle.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   start      in   1     M-extension op valid in ID/EX (sampled in IDLE only)
//   flush      in   1     kill the operation in flight
//   funct3     in   3     MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   op_a       in   XLEN  forwarded rs1
//   op_b       in   XLEN  forwarded rs2
//   stall_req  out  1     freeze request, ORed into stall_EX upstream
//   done       out  1     one-cycle pulse, result valid
//   result     out  XLEN  final value, held until the next done
//   busy       out  1     state is not IDLE
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single '*' in IDLE and
//                       complete in DONE one cycle after start; divides are
//                       unaffected. Undefined: every multiply is iterative.
// -----------------------------------------------------------------------------
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall_req,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int              DW       = 2 * XLEN;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Datapath: hi/lo hold the product halves while multiplying and the
   // remainder/quotient while dividing; dvs is the multiplicand or divisor
   // magnitude; neg records whether FIXUP must negate the selected value.
   funct3_e           op_q,  op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   hi_q,  hi_d;
   logic [XLEN-1:0]   lo_q,  lo_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;

   // ---------------------------------------------------------------------------
   // Operand magnitudes and result-sign bits
   // ---------------------------------------------------------------------------
   logic            sgn_a, sgn_b;
   logic [XLEN-1:0] abs_a, abs_b;

   assign sgn_a = op_a_signed(funct3) & op_a[XLEN-1];
   assign sgn_b = op_b_signed(funct3) & op_b[XLEN-1];

   muldiv_negate #(.W(XLEN)) u_abs_a (
      .neg_i (sgn_a),
      .val_i (op_a),
      .res_o (abs_a)
   );

   muldiv_negate #(.W(XLEN)) u_abs_b (
      .neg_i (sgn_b),
      .val_i (op_b),
      .res_o (abs_b)
   );

   // ---------------------------------------------------------------------------
   // Iteration step
   // ---------------------------------------------------------------------------
   // Multiply: conditional 33-bit add into hi, then the 65-bit {carry,hi,lo}
   // shifts right by one, retiring the multiplier bit just examined.
   logic [XLEN:0] mul_sum;
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);

   // Divide: {rem,quo} shifts left by one into a 33-bit partial remainder; a
   // non-negative difference means the divisor fits and a quotient 1 is set.
   logic [XLEN:0] div_sh;
   logic [XLEN:0] div_diff;
   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, dvs_q};

   // ---------------------------------------------------------------------------
   // Sign fix-up: one 64-bit negator serves the product and, zero-extended,
   // the 32-bit quotient or remainder (only its low word is used then).
   // ---------------------------------------------------------------------------
   logic [DW-1:0] fix_in, fix_out;

   assign fix_in = is_div_op(op_q) ? {{XLEN{1'b0}}, (is_rem_op(op_q) ? hi_q : lo_q)}
                                   : {hi_q, lo_q};

   muldiv_negate #(.W(DW)) u_fix (
      .neg_i (neg_q),
      .val_i (fix_in),
      .res_o (fix_out)
   );

`ifdef MULDIV_FAST_MUL_EN
   // Single-cycle product: sign- or zero-extend each operand to 64 bits so the
   // low 64 bits of one multiply cover MUL, MULH, MULHSU and MULHU alike.
   logic signed [DW-1:0] fast_a, fast_b;
   logic        [DW-1:0] fast_prod;

   assign fast_a    = DW'($signed({sgn_a, op_a}));
   assign fast_b    = DW'($signed({sgn_b, op_b}));
   assign fast_prod = fast_a * fast_b;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: each _d starts at its hold value so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      op_d     = op_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvs_d    = dvs_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               op_d    = funct3_e'(funct3);
               cnt_d   = CNT_INIT;
               // Remainder follows the dividend; everything else the XOR.
               neg_d   = is_rem_op(funct3) ? sgn_a : (sgn_a ^ sgn_b);
               hi_d    = '0;
               lo_d    = abs_a;
               dvs_d   = abs_b;
               state_d = ST_CALC;

               if (is_div_op(funct3)) begin
                  if (op_b == '0) begin
                     result_d = is_rem_op(funct3) ? op_a : ALL_ONES;
                     state_d  = ST_DONE;
                  end else if (op_b_signed(funct3) && (op_a == INT_MIN) && (op_b == ALL_ONES)) begin
                     result_d = is_rem_op(funct3) ? '0 : INT_MIN;
                     state_d  = ST_DONE;
                  end
               end
`ifdef MULDIV_FAST_MUL_EN
               else begin
                  result_d = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[DW-1:XLEN];
                  state_d  = ST_DONE;
               end
`endif
            end
         end

         ST_CALC: begin
            if (is_div_op(op_q)) begin
               if (!div_diff[XLEN]) begin
                  hi_d = div_diff[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_d = div_sh[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end

            if (cnt_q == '0) begin
               state_d = ST_FIXUP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_FIXUP: begin
            // MULH/MULHSU/MULHU take the upper word; MUL and divides the lower.
            if (is_div_op(op_q) || (op_q == F3_MUL)) begin
               result_d = fix_out[XLEN-1:0];
            end else begin
               result_d = fix_out[DW-1:XLEN];
            end
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A killed operation never reaches DONE and never touches result.
      if (flush) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values of
      // the previous cycle regardless of statement order.
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // NOTE: datapath registers carry no reset: they are always loaded in IDLE
   // before CALC or FIXUP reads them, and nothing observable depends on them
   // while the sequencer is idle.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      neg_q <= neg_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dvs_q <= dvs_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // stall_req drops in DONE so EX advances on the edge that ends DONE and
   // latches result into EX/MEM.
   assign stall_req = ((state_q == ST_IDLE) && start && !flush)
                    || (state_q == ST_CALC)
                    || (state_q == ST_FIXUP);
   assign done      = (state_q == ST_DONE) && !flush;
   assign busy      = (state_q != ST_IDLE);
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//
// Self-checking bench for muldiv_seq. Each operation pushes its expected result
// and done latency into a scoreboard queue when start is driven; the entry is
// popped and compared when done is seen. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. Cycle 0 is the start
// cycle. Building with MULDIV_FAST_MUL_EN shortens the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam int ITER_LAT = 34;
   localparam int SPEC_LAT = 1;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT  = 1;
`else
   localparam int MUL_LAT  = 34;
`endif
   localparam int TIMEOUT  = 100;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        stall_req;
   logic        done;
   logic [31:0] result;
   logic        busy;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .flush     (flush),
      .funct3    (funct3),
      .op_a      (op_a),
      .op_b      (op_b),
      .stall_req (stall_req),
      .done      (done),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // stall_req expected high in cycles 0..lat-1 and low in the done cycle.
   function automatic logic [63:0] stall_mask(input int lat);
      return (64'd1 << lat) - 64'd1;
   endfunction

   // Issue one operation in the next cycle and follow it to done (or timeout).
   task automatic run_op(input vec_t v, output logic [31:0] res,
                         output int done_cyc, output logic [63:0] st_tr);
      exp_t e;
      e.res = v.res;
      e.lat = v.lat;
      sb_q.push_back(e);
      res      = 'x;
      done_cyc = -1;
      st_tr    = '0;
      @(posedge clk); #1;
      start  = 1'b1;
      funct3 = v.f3;
      op_a   = v.a;
      op_b   = v.b;
      for (int cyc = 0; cyc < TIMEOUT; cyc++) begin
         @(negedge clk);
         if (cyc < 64) st_tr[cyc] = stall_req;
         if (done === 1'b1) begin
            res      = result;
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [34:0] obs;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs = {stall_req, done, busy, result};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got {stall,done,busy,result}=%h, expected 0", obs);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_mul();
      vec_t        tbl [0:6];
      exp_t        e;
      logic [31:0] r;
      int          dc;
      logic [63:0] st;
      tbl = '{
         '{"mul_7_x_m3",       OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
         '{"mulhu_max",        OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
         '{"mulh_m1_m1",       OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT},
         '{"mulhsu_m1_x_2",    OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT},
         '{"mul_3_x_4",        OP_MUL,    32'h0000_0003, 32'h0000_0004, 32'h0000_000C, MUL_LAT},
         '{"mulh_min_min",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT},
         '{"mulhsu_min_umax",  OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT}
      };
      foreach (tbl[i]) begin
         run_op(tbl[i], r, dc, st);
         e = sb_q.pop_front();
         checks++;
         if (r !== e.res) begin
            errors++;
            $display("FAIL %s result: got %08h, expected %08h", tbl[i].name, r, e.res);
         end
         checks++;
         if (dc != e.lat) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", tbl[i].name, dc, e.lat);
         end
         checks++;
         if (st !== stall_mask(e.lat)) begin
            errors++;
            $display("FAIL %s stall_trace: got %h, expected %h", tbl[i].name, st, stall_mask(e.lat));
         end
      end
   endtask

   task automatic test_div();
      vec_t        tbl [0:11];
      exp_t        e;
      logic [31:0] r;
      int          dc;
      logic [63:0] st;
      tbl = '{
         '{"div_overflow",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT},
         '{"rem_overflow",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT},
         '{"div_m7_2",       OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, ITER_LAT},
         '{"rem_m7_2",       OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, ITER_LAT},
         '{"divu_5_0",       OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT},
         '{"remu_5_0",       OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPEC_LAT},
         '{"divu_100_7",     OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, ITER_LAT},
         '{"remu_100_7",     OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, ITER_LAT},
         '{"div_20_m6",      OP_DIV,  32'h0000_0014, 32'hFFFF_FFFA, 32'hFFFF_FFFD, ITER_LAT},
         '{"rem_20_m6",      OP_REM,  32'h0000_0014, 32'hFFFF_FFFA, 32'h0000_0002, ITER_LAT},
         '{"rem_m5_0",       OP_REM,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, SPEC_LAT},
         '{"divu_min_umax",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, ITER_LAT}
      };
      foreach (tbl[i]) begin
         run_op(tbl[i], r, dc, st);
         e = sb_q.pop_front();
         checks++;
         if (r !== e.res) begin
            errors++;
            $display("FAIL %s result: got %08h, expected %08h", tbl[i].name, r, e.res);
         end
         checks++;
         if (dc != e.lat) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", tbl[i].name, dc, e.lat);
         end
         checks++;
         if (st !== stall_mask(e.lat)) begin
            errors++;
            $display("FAIL %s stall_trace: got %h, expected %h", tbl[i].name, st, stall_mask(e.lat));
         end
      end
   endtask

   task automatic test_flush();
      vec_t        pre  = '{"flush_pre_remu", OP_REMU, 32'd5, 32'd0, 32'd5, SPEC_LAT};
      vec_t        post = '{"flush_restart",  OP_DIVU, 32'd100, 32'd7, 32'd14, ITER_LAT};
      exp_t        e;
      logic [31:0] r;
      int          dc;
      logic [63:0] st;
      int          spurious = 0;

      run_op(pre, r, dc, st);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.res) begin
         errors++;
         $display("FAIL %s result: got %08h, expected %08h", pre.name, r, e.res);
      end

      // DIVU 100/7 started in cycle 0 and killed by flush in cycle 10.
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         start  = (c == 0);
         flush  = (c == 10);
         funct3 = OP_DIVU;
         op_a   = 32'd100;
         op_b   = 32'd7;
         @(negedge clk);
         if (done !== 1'b0) spurious++;
         if (c == 10) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL flush_c10_busy: got %b, expected 1", busy);
            end
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_c11_idle: busy got %b, expected 0", busy);
      end
      checks++;
      if (result !== 32'd5) begin
         errors++;
         $display("FAIL flush_result_held: got %08h, expected %08h", result, 32'd5);
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL flush_no_done: got %0d done pulses, expected 0", spurious);
      end

      // Fresh start in cycle 12 finishes in cycle 46.
      run_op(post, r, dc, st);
      e = sb_q.pop_front();
      checks++;
      if (r !== e.res) begin
         errors++;
         $display("FAIL %s result: got %08h, expected %08h", post.name, r, e.res);
      end
      checks++;
      if (dc != e.lat) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d, expected %0d", post.name, dc, e.lat);
      end
   endtask

   task automatic test_back_to_back();
      vec_t        tbl [0:2];
      exp_t        e;
      logic [31:0] r;
      int          dc;
      logic [63:0] st;
      tbl = '{
         '{"b2b_mul_ffff",    OP_MUL,   32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, MUL_LAT},
         '{"b2b_remu_100_7",  OP_REMU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, ITER_LAT},
         '{"b2b_mulhu_2p16",  OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT}
      };
      // run_op issues each start in the IDLE cycle right after the previous DONE.
      foreach (tbl[i]) begin
         run_op(tbl[i], r, dc, st);
         e = sb_q.pop_front();
         checks++;
         if (r !== e.res) begin
            errors++;
            $display("FAIL %s result: got %08h, expected %08h", tbl[i].name, r, e.res);
         end
         checks++;
         if (dc != e.lat) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", tbl[i].name, dc, e.lat);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [34:0] obs;
      int          spurious = 0;
      for (int c = 0; c <= 20; c++) begin
         @(posedge clk); #1;
         start  = (c == 0);
         rst    = (c == 20);
`ifdef MULDIV_FAST_MUL_EN
         funct3 = OP_DIVU;
`else
         funct3 = OP_MUL;
`endif
         op_a   = 32'd100;
         op_b   = 32'd7;
         @(negedge clk);
         if (done !== 1'b0) spurious++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_c20_busy: got %b, expected 1", busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      obs = {stall_req, done, busy, result};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got {stall,done,busy,result}=%h, expected 0", obs);
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL rst_mid_no_done: got %0d done pulses, expected 0", spurious);
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'd0;
      op_a   = '0;
      op_b   = '0;

      test_reset();
      test_mul();
      test_div();
      test_flush();
      test_back_to_back();
      test_reset_mid();

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained: got %0d entries left, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the EX-stage ALU. It accepts operands that are already forwarded in EX, runs a shift-add multiplier or a restoring divider over multiple cycles, and holds the pipeline through `stall_req` until the result is ready. The EX stage then latches `result` into its EX/MEM register like a normal ALU output.

## Interface
Parameters:
- `XLEN`, 32, operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  the M-extension instruction in ID/EX is valid; sampled only in IDLE
- `flush`  in  1  kill the operation in flight (EX flush on redirect)
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `op_a`  in  32  forwarded rs1 value
- `op_b`  in  32  forwarded rs2 value
- `stall_req`  out  1  freeze IF/ID/EX; ORed into `stall_EX` upstream
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle
- `result`  out  32  final value; holds until the next `done`
- `busy`  out  1  state is not IDLE

## Operation
States: IDLE, CALC, FIXUP, DONE.
- **IDLE**
  - On `start` with no `flush`: latch operands as absolute values, record result-sign bits, latch `funct3`.
  - Set `cnt` = 31 and go to CALC.
  - Divides hit a special case (see below) go straight to DONE.
- **CALC**, multiply: 64-bit accumulator `{hi,lo}`.
  - Each cycle: if `lo[0]`, add the multiplicand to `hi` (33-bit add), then shift the whole 65-bit value right by one.
- **CALC**, divide: restoring divide with a 33-bit remainder.
  - Each cycle: shift `{rem,quo}` left by one.
  - Subtract the divisor; if the difference is non-negative, keep it and set `quo[0]`.
- **CALC** exit: `cnt` decrements each cycle; leave for FIXUP when `cnt` = 0.
- **FIXUP**
  - Negate the product if the signs differ: MULH uses both operands signed; MULHSU uses only `op_a` signed.
  - Negate the quotient if the signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM).
  - Select low or high word, or quotient or remainder, into `result`. Go to DONE.
- **DONE**: pulse `done`, return to IDLE.
- Special cases, resolved in IDLE:
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = `op_a`.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- `flush` in any state returns to IDLE next cycle. No `done` is produced and `result` is unchanged.
- `flush` and `start` together in IDLE: `start` is ignored.
- `start` outside IDLE is ignored, because EX is frozen by `stall_req`.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `result` = 0, `stall_req` = 0, `done` = 0, `busy` = 0.
- Reset during any state gives IDLE on the next edge and no `done` pulse.
- `stall_req` is combinational: `(IDLE & start & ~flush) | CALC | FIXUP`. It is low in DONE, so EX advances on the edge that ends DONE.
- Latency (cycle 0 = the `start` cycle):
  - Normal operation: CALC in cycles 1–32, FIXUP in cycle 33, `done` in cycle 34.
  - Special-case divide: `done` in cycle 1.
- Throughput: one operation at a time. A back-to-back `start` is accepted at the earliest in the IDLE cycle after DONE.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - **Defined:** multiplies compute the 64-bit signed/unsigned product with a single `*` (DSP) in IDLE and go straight to DONE, giving `done` at cycle 1. Divides are unchanged.
  - **Undefined:** every multiply takes the iterative 34-cycle path.

## Structure
- Shared package `muldiv_pkg` holds:
  - the state enum;
  - the `funct3` encodings for the eight ops;
  - `MULDIV_CYCLES` = 32;
  - the special-case constants 0xFFFFFFFF and 0x80000000.
- Sub-module `muldiv_negate` is natural: conditional two's-complement of 32/64-bit values, used both for the operand absolute values and in FIXUP.
- Everything else lives in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `done` in cycle 34, `stall_req` high in cycles 0–33 and low in cycle 34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH of the same operands → 0x00000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with `done` in cycle 1; REM of the same operands → 0. DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; both give `done` in cycle 1.
- Start DIVU 100 / 7, then assert `flush` in cycle 10 → IDLE in cycle 11, no `done`, `result` unchanged. A new `start` in cycle 12 gives 14 in cycle 46.
- Assert `rst` in cycle 20 of a MUL → all outputs 0 next cycle. With `MULDIV_FAST_MUL_EN`, MUL 3 × 4 → 12 with `done` in cycle 1.
